// File: rtl/histeq_engine_param.sv
// histeq_engine_param: single-FSM histogram equalizer.
// Counts every pixel of a NUM_WORDS x LANES image into register bins, builds
// the CDF, scales it into a PIX_W-bit mapping LUT with a serial restoring
// divider, then rewrites each input word through the LUT.
// Optional feature macro: HISTEQ_CLIP_EN -- when defined, each bin saturates
// at CLIP while counting (clip-limited histogram, excess discarded).
module histeq_engine_param #(
  parameter int PIX_W     = 4,
  parameter int LANES     = 4,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 16,
  parameter int CLIP      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        in_mem_raddr,
  input  logic [LANES*PIX_W-1:0]   in_mem_rdata,
  output logic                     out_mem_WE,
  output logic [ADDR_W-1:0]        out_mem_waddr,
  output logic [LANES*PIX_W-1:0]   out_mem_wdata
);

  localparam int BINS  = 2 ** PIX_W;
  localparam int DW    = LANES * PIX_W;
  localparam int CNT_W = $clog2(LANES * NUM_WORDS + 1);
  localparam int Q_W   = CNT_W + PIX_W;
  localparam int DC_W  = $clog2(Q_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_HIST  = 3'd2,
    S_CDF   = 3'd3,
    S_SCALE = 3'd4,
    S_MAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                state_r;
  logic                  busy_r;
  logic                  done_r;
  logic [ADDR_W-1:0]     raddr_r;
  logic [ADDR_W-1:0]     cyc_r;
  logic [PIX_W-1:0]      bidx_r;
  logic [DC_W-1:0]       div_cnt_r;
  logic [CNT_W-1:0]      run_r;
  logic [CNT_W-1:0]      cdf_min_r;
  logic                  min_found_r;
  logic [CNT_W-1:0]      rem_r;
  logic [Q_W-1:0]        quo_r;
  logic [Q_W-1:0]        dvd_r;
  logic [CNT_W-1:0]      bin_r [BINS];
  logic [CNT_W-1:0]      cdf_r [BINS];
  logic [PIX_W-1:0]      lut_r [BINS];

  logic [CNT_W-1:0]      cdf_acc_s;
  logic [CNT_W-1:0]      den_s;
  logic [CNT_W-1:0]      diff_s;
  logic [Q_W-1:0]        num_s;
  logic [CNT_W:0]        rem_shift_s;
  logic [CNT_W:0]        rem_diff_s;
  logic [CNT_W-1:0]      rem_next_s;
  logic                  ge_s;
  logic [Q_W-1:0]        quo_next_s;
  logic [DW-1:0]         map_s;
  logic                  we_s;

  // Number of lanes in a word equal to value v (identical lanes all count).
  function automatic logic [CNT_W-1:0] count_match_f(input logic [DW-1:0] w,
                                                     input logic [PIX_W-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w[i*PIX_W +: PIX_W] == v) begin
        n = n + CNT_W'(1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Next bin value: exact count, or clip-limited when the clip feature is built in.
  function automatic logic [CNT_W-1:0] bin_next_f(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] m);
`ifdef HISTEQ_CLIP_EN
    logic [CNT_W:0] sum;
    sum = {1'b0, cur} + {1'b0, m};
    if (sum > (CNT_W+1)'(CLIP)) begin
      return CNT_W'(CLIP);
    end else begin
      return sum[CNT_W-1:0];
    end
`else
    return cur + m;
`endif
  endfunction

  // Clamp a divider quotient to the largest pixel value.
  function automatic logic [PIX_W-1:0] sat_f(input logic [Q_W-1:0] q);
    if (q > Q_W'(BINS - 1)) begin
      return PIX_W'(BINS - 1);
    end else begin
      return q[PIX_W-1:0];
    end
  endfunction

  // CDF accumulation, scaling numerator and one restoring-divider step.
  always_comb begin
    cdf_acc_s   = run_r + bin_r[bidx_r];
    den_s       = cdf_r[BINS-1] - cdf_min_r;
    if (cdf_r[bidx_r] > cdf_min_r) begin
      diff_s = cdf_r[bidx_r] - cdf_min_r;
    end else begin
      diff_s = '0;
    end
    num_s       = Q_W'(diff_s) * Q_W'(BINS - 1) + Q_W'(den_s >> 1);
    rem_shift_s = {rem_r, dvd_r[Q_W-1]};
    rem_diff_s  = rem_shift_s - {1'b0, den_s};
    if (rem_shift_s >= {1'b0, den_s}) begin
      ge_s       = 1'b1;
      rem_next_s = rem_diff_s[CNT_W-1:0];
    end else begin
      ge_s       = 1'b0;
      rem_next_s = rem_shift_s[CNT_W-1:0];
    end
    quo_next_s  = (quo_r << 1) | Q_W'(ge_s);
  end

  // Output write path: LUT-mapped read data, valid one cycle after each MAP address.
  always_comb begin
    map_s = '0;
    for (int i = 0; i < LANES; i++) begin
      map_s[i*PIX_W +: PIX_W] = lut_r[in_mem_rdata[i*PIX_W +: PIX_W]];
    end
    we_s = (state_r == S_MAP) && (cyc_r != '0);
    if (we_s) begin
      out_mem_waddr = cyc_r - ADDR_W'(1);
      out_mem_wdata = map_s;
    end else begin
      out_mem_waddr = '0;
      out_mem_wdata = '0;
    end
  end

  assign out_mem_WE   = we_s;
  assign busy         = busy_r;
  assign done         = done_r;
  assign in_mem_raddr = raddr_r;

  // Main controller: clear, histogram, CDF, serial scaling divide, mapping pass.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      raddr_r     <= '0;
      cyc_r       <= '0;
      bidx_r      <= '0;
      div_cnt_r   <= '0;
      run_r       <= '0;
      cdf_min_r   <= '0;
      min_found_r <= 1'b0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvd_r       <= '0;
      for (int b = 0; b < BINS; b++) begin
        bin_r[b] <= '0;
        cdf_r[b] <= '0;
        lut_r[b] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_CLEAR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CLEAR: begin
          for (int b = 0; b < BINS; b++) begin
            bin_r[b] <= '0;
          end
          raddr_r <= '0;
          cyc_r   <= '0;
          state_r <= S_HIST;
        end
        S_HIST: begin
          if (cyc_r != '0) begin
            for (int b = 0; b < BINS; b++) begin
              bin_r[b] <= bin_next_f(bin_r[b], count_match_f(in_mem_rdata, PIX_W'(b)));
            end
          end
          if (cyc_r < ADDR_W'(NUM_WORDS - 1)) begin
            raddr_r <= cyc_r + ADDR_W'(1);
          end
          if (cyc_r == ADDR_W'(NUM_WORDS)) begin
            state_r     <= S_CDF;
            bidx_r      <= '0;
            run_r       <= '0;
            cdf_min_r   <= '0;
            min_found_r <= 1'b0;
          end else begin
            cyc_r <= cyc_r + ADDR_W'(1);
          end
        end
        S_CDF: begin
          cdf_r[bidx_r] <= cdf_acc_s;
          run_r         <= cdf_acc_s;
          if (!min_found_r && (cdf_acc_s != '0)) begin
            cdf_min_r   <= cdf_acc_s;
            min_found_r <= 1'b1;
          end
          if (bidx_r == PIX_W'(BINS - 1)) begin
            state_r   <= S_SCALE;
            bidx_r    <= '0;
            div_cnt_r <= '0;
          end else begin
            bidx_r <= bidx_r + PIX_W'(1);
          end
        end
        S_SCALE: begin
          if (den_s == '0) begin
            // Flat image: identity mapping, no division needed.
            for (int b = 0; b < BINS; b++) begin
              lut_r[b] <= PIX_W'(b);
            end
            state_r <= S_MAP;
            raddr_r <= '0;
            cyc_r   <= '0;
          end else if (div_cnt_r == '0) begin
            dvd_r     <= num_s;
            rem_r     <= '0;
            quo_r     <= '0;
            div_cnt_r <= DC_W'(1);
          end else begin
            dvd_r <= dvd_r << 1;
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (div_cnt_r == DC_W'(Q_W)) begin
              lut_r[bidx_r] <= sat_f(quo_next_s);
              div_cnt_r     <= '0;
              if (bidx_r == PIX_W'(BINS - 1)) begin
                state_r <= S_MAP;
                raddr_r <= '0;
                cyc_r   <= '0;
              end else begin
                bidx_r <= bidx_r + PIX_W'(1);
              end
            end else begin
              div_cnt_r <= div_cnt_r + DC_W'(1);
            end
          end
        end
        S_MAP: begin
          if (cyc_r < ADDR_W'(NUM_WORDS - 1)) begin
            raddr_r <= cyc_r + ADDR_W'(1);
          end
          if (cyc_r == ADDR_W'(NUM_WORDS)) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cyc_r <= cyc_r + ADDR_W'(1);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histeq_engine_param.sv
// tb_histeq_engine_param: directed + randomized checks of histeq_engine_param
// against a behavioural histogram-equalization model (PIX_W=4, LANES=4,
// NUM_WORDS=4). Honors HISTEQ_CLIP_EN in the model with CLIP=4.
module tb_histeq_engine_param;

  localparam int CLIP_V = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] in_mem_raddr;
  logic [15:0] in_mem_rdata;
  logic        out_mem_WE;
  logic [15:0] out_mem_waddr;
  logic [15:0] out_mem_wdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] img   [4];
  logic [15:0] exp_w [4];

  logic [15:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  int          done_cnt;
  int          cyc_cnt = 0;
  int          last_we_cyc;
  int          done_cyc;

  histeq_engine_param #(
    .PIX_W(4), .LANES(4), .NUM_WORDS(4), .ADDR_W(16), .CLIP(CLIP_V)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .in_mem_raddr  (in_mem_raddr),
    .in_mem_rdata  (in_mem_rdata),
    .out_mem_WE    (out_mem_WE),
    .out_mem_waddr (out_mem_waddr),
    .out_mem_wdata (out_mem_wdata)
  );

  always #5 clock = ~clock;

  // Input memory: synchronous read, data one cycle after the address.
  always @(posedge clock) begin
    in_mem_rdata <= (in_mem_raddr < 16'd4) ? img[in_mem_raddr[1:0]] : 16'h0000;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clock) begin
    cyc_cnt = cyc_cnt + 1;
    if (out_mem_WE) begin
      wr_addr_q.push_back(out_mem_waddr);
      wr_data_q.push_back(out_mem_wdata);
      last_we_cyc = cyc_cnt;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: histogram -> (clip) -> CDF -> rounded scaled LUT -> mapped words.
  task automatic compute_model();
    int hist [16];
    int cdf  [16];
    int lut  [16];
    int cmin, total, den, num, q, run;
    logic [15:0] v;
    for (int b = 0; b < 16; b++) hist[b] = 0;
    for (int w = 0; w < 4; w++)
      for (int l = 0; l < 4; l++)
        hist[(img[w] >> (4*l)) & 16'h000F]++;
`ifdef HISTEQ_CLIP_EN
    for (int b = 0; b < 16; b++) if (hist[b] > CLIP_V) hist[b] = CLIP_V;
`endif
    run  = 0;
    cmin = 0;
    for (int b = 0; b < 16; b++) begin
      run    = run + hist[b];
      cdf[b] = run;
      if (cmin == 0 && run != 0) cmin = run;
    end
    total = cdf[15];
    den   = total - cmin;
    for (int b = 0; b < 16; b++) begin
      if (den == 0) begin
        lut[b] = b;
      end else begin
        num = ((cdf[b] > cmin) ? (cdf[b] - cmin) : 0) * 15 + den / 2;
        q   = num / den;
        lut[b] = (q > 15) ? 15 : q;
      end
    end
    for (int w = 0; w < 4; w++) begin
      v = 16'h0000;
      for (int l = 0; l < 4; l++)
        v = v | (16'(lut[(img[w] >> (4*l)) & 16'h000F]) << (4*l));
      exp_w[w] = v;
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt    = 0;
    last_we_cyc = -100;
    done_cyc    = -200;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  // Run one image; optionally pulse start mid-run (cycle mid_at) and on the done cycle.
  task automatic run_case(input string tag, input int mid_at, input bit start_on_done);
    bit seen;
    compute_model();
    clear_mon();
    pulse_start();
    seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(posedge clock); #1;
      start = (n == mid_at) ? 1'b1 : 1'b0;
      if (n == mid_at) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    if (seen && start_on_done) begin
      start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
    repeat (40) @(posedge clock);
    #1;
    check({tag, "_nwrites"}, wr_data_q.size(), 32'd4);
    for (int k = 0; k < wr_data_q.size() && k < 4; k++) begin
      check({tag, "_waddr"}, {16'd0, wr_addr_q[k]}, k);
      check({tag, "_wdata"}, {16'd0, wr_data_q[k]}, {16'd0, exp_w[k]});
    end
    check({tag, "_ndone"}, done_cnt, 32'd1);
    check({tag, "_done_lat"}, done_cyc - last_we_cyc, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) img[k] = 16'h0000;
    clear_mon();
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_we",    {31'd0, out_mem_WE}, 32'd0);
    check("rst_raddr", {16'd0, in_mem_raddr},  32'd0);
    check("rst_waddr", {16'd0, out_mem_waddr}, 32'd0);
    check("rst_wdata", {16'd0, out_mem_wdata}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // 1: flat image -> identity
    for (int k = 0; k < 4; k++) img[k] = 16'h7777;
    run_case("flat", -1, 1'b0);
    for (int k = 0; k < wr_data_q.size() && k < 4; k++)
      check("flat_const", {16'd0, wr_data_q[k]}, 32'h7777);

    // 2: each value once -> identity
    img[0] = 16'h3210; img[1] = 16'h7654; img[2] = 16'hBA98; img[3] = 16'hFEDC;
    run_case("ramp", -1, 1'b0);
    for (int k = 0; k < wr_data_q.size() && k < 4; k++)
      check("ramp_ident", {16'd0, wr_data_q[k]}, {16'd0, img[k]});

    // 3: two levels
    img[0] = 16'h0000; img[1] = 16'h0000; img[2] = 16'hFFFF; img[3] = 16'hFFFF;
    run_case("twolvl", -1, 1'b0);

    // 4: 2x1, 10x6, 4x12
    img[0] = 16'h6611; img[1] = 16'h6666; img[2] = 16'h6666; img[3] = 16'hCCCC;
    run_case("skew", -1, 1'b0);
    if (wr_data_q.size() == 4) begin
`ifdef HISTEQ_CLIP_EN
      check("skew_lut6", {16'd0, wr_data_q[1]}, 32'h8888);
`else
      check("skew_lut6", {16'd0, wr_data_q[1]}, 32'hBBBB);
      check("skew_w0",   {16'd0, wr_data_q[0]}, 32'hBB00);
`endif
      check("skew_lut12", {16'd0, wr_data_q[3]}, 32'hFFFF);
    end else begin
      check("skew_words", wr_data_q.size(), 32'd4);
    end

    // 5: reset mid-HIST, then a clean run of the ramp image
    img[0] = 16'h3210; img[1] = 16'h7654; img[2] = 16'hBA98; img[3] = 16'hFEDC;
    clear_mon();
    pulse_start();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    repeat (60) @(posedge clock);
    #1;
    check("rstmid_nowe", wr_data_q.size(), 32'd0);
    run_case("rstmid_run", -1, 1'b0);

    // 6: start during SCALE and on the done cycle are ignored
    run_case("ignstart", 60, 1'b1);

    // Randomized images: full range and a narrow band
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r < 3) begin
          img[k] = 16'($urandom);
        end else begin
          img[k] = 16'h0000;
          for (int l = 0; l < 4; l++)
            img[k] = img[k] | (16'($urandom_range(9, 5)) << (4*l));
        end
      end
      run_case("rand", -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
